// File: rtl/imem_hier_p.sv
// imem_hier_p: direct-mapped instruction cache with a Wishbone B3 burst-refill master.
// Optional full-cache flush is compiled in when ICACHE_FLUSH_EN is defined.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | no request in flight, ready to accept
// S_LOOKUP | tag compare for req_addr; hit delivers, miss starts refill
// S_REFILL | one setup cycle, then LINE_WORDS bus beats into the data array
// S_UPDATE | write tag, set valid, re-lookup next cycle (guaranteed hit)
// S_ERR    | refill hit a bus error; present NOP with fetch_err for one cycle
// S_FLUSH  | clear one valid bit per cycle (ICACHE_FLUSH_EN only)
module imem_hier_p #(
    parameter int ADDR_W     = 32,
    parameter int LINE_WORDS = 8,
    parameter int SETS       = 128
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    input  logic              freeze,
    output logic [31:0]       instr_out,
    output logic              instr_valid,
    output logic              fetch_err,
    output logic              stall_out,
`ifdef ICACHE_FLUSH_EN
    input  logic              flush,
`endif
    output logic              wb_cyc_o,
    output logic              wb_stb_o,
    output logic              wb_we_o,
    output logic [ADDR_W-1:0] wb_adr_o,
    output logic [3:0]        wb_sel_o,
    output logic [31:0]       wb_dat_o,
    output logic [2:0]        wb_cti_o,
    output logic [1:0]        wb_bte_o,
    input  logic              wb_ack_i,
    input  logic              wb_err_i,
    input  logic [31:0]       wb_dat_i
);

    localparam int OFF_W = $clog2(LINE_WORDS);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = ADDR_W - IDX_W - OFF_W - 2;

    localparam logic [31:0]      NOP       = 32'h0000_0013;
    localparam logic [2:0]       CTI_INC   = 3'b010;
    localparam logic [2:0]       CTI_EOB   = 3'b111;
    localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(LINE_WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOOKUP = 3'd1,
        S_REFILL = 3'd2,
        S_UPDATE = 3'd3,
        S_ERR    = 3'd4
`ifdef ICACHE_FLUSH_EN
        , S_FLUSH = 3'd5
`endif
    } state_t;

    // Where a flush request sends the FSM; without the feature flush_req is tied low.
`ifdef ICACHE_FLUSH_EN
    localparam state_t FLUSH_TGT = S_FLUSH;
`else
    localparam state_t FLUSH_TGT = S_IDLE;
`endif

    state_t state_q, state_d;

    logic [31:0]       data_mem [SETS*LINE_WORDS];
    logic [TAG_W-1:0]  tag_mem  [SETS];
    logic [SETS-1:0]   valid_q;

    logic [ADDR_W-1:0] req_addr;
    logic [ADDR_W-1:0] rd_addr;
    logic [TAG_W-1:0]  req_tag;
    logic [IDX_W-1:0]  req_idx;
    logic [IDX_W-1:0]  rd_idx;
    logic [OFF_W-1:0]  rd_off;
    logic [OFF_W-1:0]  beat_cnt;
    logic [OFF_W-1:0]  beat_nxt;
    logic [31:0]       rd_data;
    logic [31:0]       hold_instr;
    logic              hold_valid;
    logic              hold_err;
    logic [31:0]       cur_instr;
    logic              cur_valid;
    logic              cur_err;
    logic              hit;
    logic              accept;
    logic              last_beat;
    logic              bus_ack;
    logic              flush_req;
    logic              unused_addr_bits;

    assign req_tag   = req_addr[ADDR_W-1 -: TAG_W];
    assign req_idx   = req_addr[OFF_W+2 +: IDX_W];
    assign rd_addr   = accept ? fetch_addr : req_addr;
    assign rd_idx    = rd_addr[OFF_W+2 +: IDX_W];
    assign rd_off    = rd_addr[2 +: OFF_W];
    assign beat_nxt  = beat_cnt + 1'b1;
    assign last_beat = (beat_cnt == LAST_BEAT);
    assign bus_ack   = wb_cyc_o && wb_ack_i && !wb_err_i;
    assign hit       = (state_q == S_LOOKUP) && valid_q[req_idx] && (tag_mem[req_idx] == req_tag);

    assign unused_addr_bits = ^{fetch_addr[1:0], req_addr[1:0]};

    assign wb_stb_o = wb_cyc_o;
    assign wb_we_o  = 1'b0;
    assign wb_sel_o = 4'hF;
    assign wb_dat_o = 32'h0;
    assign wb_bte_o = 2'b00;

    // While frozen the fetch side sees the copy taken in the last unfrozen cycle.
    assign instr_out   = freeze ? hold_instr : cur_instr;
    assign instr_valid = freeze ? hold_valid : cur_valid;
    assign fetch_err   = freeze ? hold_err   : cur_err;

`ifdef ICACHE_FLUSH_EN
    logic             flush_pend;
    logic [IDX_W-1:0] flush_cnt;

    assign flush_req = flush | flush_pend;

    // Remember a flush that cannot start yet; walk the valid array during S_FLUSH.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flush_pend <= 1'b0;
            flush_cnt  <= '0;
        end else begin
            flush_pend <= (flush_pend | flush) & (state_d != S_FLUSH);
            if (state_q == S_FLUSH) flush_cnt <= flush_cnt + 1'b1;
        end
    end
`else
    assign flush_req = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state, request acceptance and the unfrozen fetch-side outputs.
    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        cur_instr = hold_instr;
        cur_valid = 1'b0;
        cur_err   = 1'b0;
        stall_out = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (flush_req) begin
                    state_d = FLUSH_TGT;
                end else if (fetch_req && !freeze) begin
                    accept  = 1'b1;
                    state_d = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (hit) begin
                    cur_instr = rd_data;
                    cur_valid = 1'b1;
                    if (freeze) begin
                        state_d = S_LOOKUP;
                    end else if (flush_req) begin
                        state_d = FLUSH_TGT;
                    end else if (fetch_req) begin
                        accept  = 1'b1;
                        state_d = S_LOOKUP;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    stall_out = 1'b1;
                    state_d   = flush_req ? FLUSH_TGT : S_REFILL;
                end
            end
            S_REFILL: begin
                stall_out = 1'b1;
                if (wb_cyc_o && wb_err_i)          state_d = S_ERR;
                else if (bus_ack && last_beat)     state_d = S_UPDATE;
            end
            S_UPDATE: begin
                stall_out = 1'b1;
                state_d   = flush_req ? FLUSH_TGT : S_LOOKUP;
            end
            S_ERR: begin
                cur_instr = NOP;
                cur_valid = 1'b1;
                cur_err   = 1'b1;
                if (freeze) begin
                    state_d = S_ERR;
                end else if (flush_req) begin
                    state_d = FLUSH_TGT;
                end else if (fetch_req) begin
                    accept  = 1'b1;
                    state_d = S_LOOKUP;
                end else begin
                    state_d = S_IDLE;
                end
            end
`ifdef ICACHE_FLUSH_EN
            S_FLUSH: begin
                stall_out = 1'b1;
                if (flush_cnt == IDX_W'(SETS - 1)) state_d = S_IDLE;
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // Request capture, synchronous array read, freeze copy, valid bits and bus master.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            req_addr   <= '0;
            rd_data    <= '0;
            hold_instr <= '0;
            hold_valid <= 1'b0;
            hold_err   <= 1'b0;
            valid_q    <= '0;
            beat_cnt   <= '0;
            wb_cyc_o   <= 1'b0;
            wb_adr_o   <= '0;
            wb_cti_o   <= 3'b000;
        end else begin
            if (accept) req_addr <= fetch_addr;
            rd_data <= data_mem[{rd_idx, rd_off}];
            if (!freeze) begin
                hold_instr <= cur_instr;
                hold_valid <= cur_valid;
                hold_err   <= cur_err;
            end
            case (state_q)
                S_LOOKUP: begin
                    // Line is invalidated up front so a partial refill never looks valid.
                    if (!hit && !flush_req) begin
                        valid_q[req_idx] <= 1'b0;
                        beat_cnt         <= '0;
                        wb_adr_o         <= {req_addr[ADDR_W-1:OFF_W+2], {OFF_W{1'b0}}, 2'b00};
                        wb_cti_o         <= CTI_INC;
                    end
                end
                S_REFILL: begin
                    if (!wb_cyc_o) begin
                        wb_cyc_o <= 1'b1;
                    end else if (wb_err_i) begin
                        wb_cyc_o         <= 1'b0;
                        valid_q[req_idx] <= 1'b0;
                    end else if (wb_ack_i) begin
                        beat_cnt <= beat_nxt;
                        if (last_beat) begin
                            wb_cyc_o <= 1'b0;
                        end else begin
                            wb_adr_o <= {req_addr[ADDR_W-1:OFF_W+2], beat_nxt, 2'b00};
                            wb_cti_o <= (beat_nxt == LAST_BEAT) ? CTI_EOB : CTI_INC;
                        end
                    end
                end
                S_UPDATE: valid_q[req_idx] <= 1'b1;
`ifdef ICACHE_FLUSH_EN
                S_FLUSH:  valid_q[flush_cnt] <= 1'b0;
`endif
                default: ;
            endcase
        end
    end

    // Data and tag storage, written by refill beats and the update cycle.
    always_ff @(posedge clk) begin
        if (state_q == S_REFILL && bus_ack) data_mem[{req_idx, beat_cnt}] <= wb_dat_i;
        if (state_q == S_UPDATE)            tag_mem[req_idx] <= req_tag;
    end

endmodule
